// File: rtl/snake_pkg.sv
// Shared constants for the snake-game tick scheduler: FSM state encoding,
// speed and digit-index widths, and the prescaler limit helper.
package snake_pkg;

  localparam int SPEED_W = 2;
  localparam int DIGIT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  // Prescaler count at which a step fires; faster speeds fire sooner.
  function automatic logic [1:0] presc_limit(input logic [SPEED_W-1:0] spd);
    return 2'd3 - spd;
  endfunction

endpackage

// File: rtl/tick_sched_edge_det.sv
// Rising-edge detector for an already-synchronous button level.
// The first clock after reset only loads the history, so a button held
// through reset release never registers as a press.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic lvl,
  output logic rise
);

  logic prev_q, prev_d;
  logic armed_q, armed_d;

  // Next history: previous level, and armed once a clock has passed.
  always_comb begin
    prev_d  = lvl;
    armed_d = 1'b1;
  end

  // History and arm flops, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

  assign rise = armed_q & lvl & ~prev_q;

endmodule

// File: rtl/tick_sched.sv
// Snake-game tick scheduler: game FSM, speed-dependent step prescaler,
// step request handshake with missed-step counter, and display scan index.
// Optional feature: define TICK_SCHED_BLINK_EN to blink the display while
// paused or game over; otherwise blink is tied low and no counter exists.
module tick_sched
  import snake_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int MISS_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               move_tick,
  input  logic               scan_tick,
  input  logic               start,
  input  logic               pause,
  input  logic [SPEED_W-1:0] speed,
  input  logic               step_ack,
  input  logic               game_over,
  output logic               step_req,
  output logic               restart,
  output logic               scan_en,
  output logic [DIGIT_W-1:0] digit_sel,
  output logic [1:0]         state,
  output logic [MISS_W-1:0]  missed_cnt,
  output logic               blink
);

  localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(N_DIGITS - 1);
  localparam logic [MISS_W-1:0]  MISS_MAX   = {MISS_W{1'b1}};

  state_t               state_q, state_d;
  logic [1:0]           presc_q, presc_d;
  logic                 step_req_q, step_req_d;
  logic                 restart_q, restart_d;
  logic                 scan_en_q, scan_en_d;
  logic [DIGIT_W-1:0]   digit_q, digit_d;
  logic [MISS_W-1:0]    missed_q, missed_d;

  logic start_rise, pause_rise;
  logic start_run, to_idle, in_run, fire;

  edge_det u_start_edge (
    .clk  (clk),
    .rst  (rst),
    .lvl  (start),
    .rise (start_rise)
  );

  edge_det u_pause_edge (
    .clk  (clk),
    .rst  (rst),
    .lvl  (pause),
    .rise (pause_rise)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; game_over outranks a pause press while running.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_rise) state_d = ST_RUN;
      ST_RUN: begin
        if (game_over)       state_d = ST_OVER;
        else if (pause_rise) state_d = ST_PAUSE;
      end
      ST_PAUSE: if (pause_rise) state_d = ST_RUN;
      ST_OVER:  if (start_rise) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: game start strobe, return-to-idle strobe, run window.
  always_comb begin
    start_run = (state_q == ST_IDLE) && start_rise;
    to_idle   = (state_q == ST_OVER) && start_rise;
    in_run    = (state_q == ST_RUN);
    restart_d = start_run;
  end

  // Prescaler, step handshake, missed counter and scan index.
  always_comb begin
    fire       = in_run && move_tick && (presc_q >= presc_limit(speed));
    presc_d    = presc_q;
    missed_d   = missed_q;
    step_req_d = (step_req_q && !step_ack) || fire;
    digit_d    = digit_q;
    scan_en_d  = scan_tick;

    if (start_run) begin
      presc_d = 2'd0;
    end else if (in_run && move_tick) begin
      presc_d = fire ? 2'd0 : presc_q + 2'd1;
    end

    if (start_run) begin
      missed_d = '0;
    end else if (fire && step_req_q && !step_ack && (missed_q != MISS_MAX)) begin
      missed_d = missed_q + MISS_W'(1);
    end

    if (to_idle) begin
      step_req_d = 1'b0;
    end

    if (scan_tick) begin
      digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + DIGIT_W'(1);
    end
  end

  // Datapath registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= 2'd0;
      step_req_q <= 1'b0;
      restart_q  <= 1'b0;
      scan_en_q  <= 1'b0;
      digit_q    <= '0;
      missed_q   <= '0;
    end else begin
      presc_q    <= presc_d;
      step_req_q <= step_req_d;
      restart_q  <= restart_d;
      scan_en_q  <= scan_en_d;
      digit_q    <= digit_d;
      missed_q   <= missed_d;
    end
  end

`ifdef TICK_SCHED_BLINK_EN
  logic [1:0] blink_cnt_q, blink_cnt_d;
  logic       blink_q, blink_d;

  // Blink phase: toggle every fourth move_tick while paused or over.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if ((state_q == ST_PAUSE) || (state_q == ST_OVER)) begin
      if (move_tick) begin
        blink_cnt_d = blink_cnt_q + 2'd1;
        if (blink_cnt_q == 2'd3) begin
          blink_d = ~blink_q;
        end
      end
    end else begin
      blink_cnt_d = 2'd0;
      blink_d     = 1'b0;
    end
  end

  // Blink registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= 2'd0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif

  assign state      = state_q;
  assign step_req   = step_req_q;
  assign restart    = restart_q;
  assign scan_en    = scan_en_q;
  assign digit_sel  = digit_q;
  assign missed_cnt = missed_q;

endmodule

// File: tb/tb_tick_sched.sv
// Self-checking bench for tick_sched: table vectors, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_tick_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       move_tick, scan_tick, start, pause, step_ack, game_over;
  logic [1:0] speed;

  logic       step_req, restart, scan_en, blink;
  logic [2:0] digit_sel;
  logic [1:0] state;
  logic [7:0] missed_cnt;

  logic       step_req2, restart2, scan_en2, blink2;
  logic [2:0] digit_sel2;
  logic [1:0] state2;
  logic [1:0] missed_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tick_sched #(.N_DIGITS(6), .MISS_W(8)) dut (
    .clk(clk), .rst(rst), .move_tick(move_tick), .scan_tick(scan_tick),
    .start(start), .pause(pause), .speed(speed), .step_ack(step_ack),
    .game_over(game_over), .step_req(step_req), .restart(restart),
    .scan_en(scan_en), .digit_sel(digit_sel), .state(state),
    .missed_cnt(missed_cnt), .blink(blink)
  );

  tick_sched #(.N_DIGITS(8), .MISS_W(2)) dut2 (
    .clk(clk), .rst(rst), .move_tick(move_tick), .scan_tick(scan_tick),
    .start(start), .pause(pause), .speed(speed), .step_ack(step_ack),
    .game_over(game_over), .step_req(step_req2), .restart(restart2),
    .scan_en(scan_en2), .digit_sel(digit_sel2), .state(state2),
    .missed_cnt(missed_cnt2), .blink(blink2)
  );

  // Behavioural model: game phase 0..3 as numbers, counters as ints.
  int m_st, m_presc, m_missed, m_missed2, m_digit, m_blink_cnt;
  bit m_req, m_restart, m_scan_en, m_blink, m_first, m_sp, m_pp;
  int rises;
  bit prev_req_s;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_presc = 0; m_missed = 0; m_missed2 = 0; m_digit = 0;
    m_blink_cnt = 0; m_req = 0; m_restart = 0; m_scan_en = 0; m_blink = 0;
    m_first = 1; m_sp = 0; m_pp = 0;
  endtask

  task automatic model_step();
    bit sr, pr, fire;
    sr = !m_first && start && !m_sp;
    pr = !m_first && pause && !m_pp;
    m_sp = start; m_pp = pause; m_first = 0;
    fire = (m_st == 1) && move_tick && (m_presc >= 3 - int'(speed));
`ifdef TICK_SCHED_BLINK_EN
    if (m_st >= 2) begin
      if (move_tick) begin
        m_blink_cnt++;
        if (m_blink_cnt == 4) begin m_blink_cnt = 0; m_blink = !m_blink; end
      end
    end else begin
      m_blink_cnt = 0; m_blink = 0;
    end
`endif
    m_restart = (m_st == 0) && sr;
    if (m_st == 0 && sr) begin
      m_missed = 0; m_missed2 = 0;
    end else if (fire && m_req && !step_ack) begin
      m_missed  = (m_missed  < 255) ? m_missed + 1  : 255;
      m_missed2 = (m_missed2 < 3)   ? m_missed2 + 1 : 3;
    end
    if (m_st == 3 && sr) m_req = 0;
    else m_req = (m_req && !step_ack) || fire;
    if (m_st == 0 && sr) m_presc = 0;
    else if (m_st == 1 && move_tick) m_presc = fire ? 0 : m_presc + 1;
    if (scan_tick) m_digit = (m_digit + 1) % 6;
    m_scan_en = scan_tick;
    case (m_st)
      0: if (sr) m_st = 1;
      1: if (game_over) m_st = 3; else if (pr) m_st = 2;
      2: if (pr) m_st = 1;
      default: if (sr) m_st = 0;
    endcase
  endtask

  task automatic compare_all();
    check("state", int'(state), m_st);
    check("step_req", int'(step_req), int'(m_req));
    check("restart", int'(restart), int'(m_restart));
    check("scan_en", int'(scan_en), int'(m_scan_en));
    check("digit_sel", int'(digit_sel), m_digit);
    check("missed_cnt", int'(missed_cnt), m_missed);
    check("missed_cnt_w2", int'(missed_cnt2), m_missed2);
    check("blink", int'(blink), int'(m_blink));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    if (step_req && !prev_req_s) rises++;
    prev_req_s = step_req;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check("rst_state", int'(state), 0);
    check("rst_step_req", int'(step_req), 0);
    check("rst_restart", int'(restart), 0);
    check("rst_scan_en", int'(scan_en), 0);
    check("rst_digit", int'(digit_sel), 0);
    check("rst_missed", int'(missed_cnt), 0);
    check("rst_blink", int'(blink), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    prev_req_s = 0;
  endtask

  typedef struct {
    bit st, pa, mv, ak, go;
    int ex_state, ex_req, ex_restart;
  } vec_t;

  vec_t tbl[12];
  int   tog;
  bit   pb;

  initial begin
    rst = 1'b0; move_tick = 0; scan_tick = 0; start = 0; pause = 0;
    step_ack = 0; game_over = 0; speed = 2'd3; rises = 0; prev_req_s = 0;

    tbl[0]  = '{1, 0, 0, 0, 0, 1, 0, 1};
    tbl[1]  = '{0, 0, 1, 0, 0, 1, 1, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 1, 1, 0};
    tbl[3]  = '{0, 0, 0, 1, 0, 1, 0, 0};
    tbl[4]  = '{0, 1, 0, 0, 0, 2, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 2, 0, 0};
    tbl[6]  = '{0, 0, 1, 0, 0, 2, 0, 0};
    tbl[7]  = '{0, 1, 0, 0, 0, 1, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 1, 0, 0};
    tbl[9]  = '{0, 1, 0, 0, 1, 3, 0, 0};
    tbl[10] = '{1, 0, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0};

    @(posedge clk); #1;
    do_reset();

    // Scan index wraps at 6 and scan_en lags scan_tick by one cycle.
    for (int i = 0; i < 13; i++) begin
      scan_tick = 1; step();
      check("scan_digit", int'(digit_sel), (i + 1) % 6);
      check("scan_en_hi", int'(scan_en), 1);
      scan_tick = 0; step();
      check("scan_en_lo", int'(scan_en), 0);
    end

    // Table vectors: start, step, ack, pause round trip, pause+game_over, back to idle.
    for (int i = 0; i < 12; i++) begin
      start = tbl[i].st; pause = tbl[i].pa; move_tick = tbl[i].mv;
      step_ack = tbl[i].ak; game_over = tbl[i].go;
      step();
      check($sformatf("tbl%0d_state", i), int'(state), tbl[i].ex_state);
      check($sformatf("tbl%0d_req", i), int'(step_req), tbl[i].ex_req);
      check($sformatf("tbl%0d_restart", i), int'(restart), tbl[i].ex_restart);
    end
    start = 0; pause = 0; move_tick = 0; step_ack = 0; game_over = 0;

    // Withheld ack: missed count climbs, narrow counter saturates.
    speed = 2'd3;
    start = 1; step(); start = 0; step();
    check("run_state", int'(state), 1);
    check("run_missed_clr", int'(missed_cnt), 0);
    for (int i = 0; i < 5; i++) begin
      move_tick = 1; step(); move_tick = 0; step();
    end
    check("held_req", int'(step_req), 1);
    check("missed_4", int'(missed_cnt), 4);
    check("missed_w2_sat", int'(missed_cnt2), 3);
    for (int i = 0; i < 4; i++) begin
      move_tick = 1; step(); move_tick = 0; step();
    end
    check("missed_8", int'(missed_cnt), 8);
    check("missed_w2_still_sat", int'(missed_cnt2), 3);
    step_ack = 1; step(); step_ack = 0; step();
    check("ack_clears_req", int'(step_req), 0);

    // Step rate versus speed, ack two cycles after each request.
    for (int s = 0; s < 2; s++) begin
      speed = (s == 0) ? 2'd3 : 2'd0;
      rises = 0;
      for (int i = 0; i < 8; i++) begin
        move_tick = 1; step(); move_tick = 0; step();
        step_ack = step_req; step(); step_ack = 0; step();
      end
      check((s == 0) ? "rate_speed3" : "rate_speed0", rises, (s == 0) ? 8 : 2);
    end

    // Blink while paused.
    pause = 1; step(); pause = 0; step();
    check("paused", int'(state), 2);
    tog = 0; pb = blink;
    for (int i = 0; i < 8; i++) begin
      move_tick = 1; step(); move_tick = 0; step();
      if (blink != pb) tog++;
      pb = blink;
    end
`ifdef TICK_SCHED_BLINK_EN
    check("blink_toggles", tog, 2);
`else
    check("blink_toggles", tog, 0);
`endif

    // Button held through reset release gives no edge.
    start = 1;
    do_reset();
    for (int i = 0; i < 3; i++) step();
    check("held_start_idle", int'(state), 0);
    start = 0; step();

    // Asynchronous reset drops a pending request before any clock edge.
    speed = 2'd3;
    start = 1; step(); start = 0; step();
    move_tick = 1; step(); move_tick = 0; step();
    check("pending_before_rst", int'(step_req), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_req", int'(step_req), 0);
    check("async_rst_state", int'(state), 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    prev_req_s = 0;

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      start     = ($urandom_range(0, 99) < 5);
      pause     = ($urandom_range(0, 99) < 8);
      game_over = ($urandom_range(0, 99) < 3);
      step_ack  = ($urandom_range(0, 99) < 35);
      move_tick = ($urandom_range(0, 99) < 30);
      scan_tick = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 5) speed = 2'($urandom_range(0, 3));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
